// File: rtl/result_drain_packer.sv
// rtl/result_drain_packer.sv - drains the FP16 result FIFO and packs 16 results per 256-bit beat
module result_drain_packer #(
    parameter int RES_W  = 16,
    parameter int BEAT_W = 256,
    parameter int CNT_W  = 15
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_results,
    output logic              o_result_fifo_ren,
    input  logic [RES_W-1:0]  i_result_fifo_rdata,
    input  logic              i_result_fifo_empty,
    output logic [BEAT_W-1:0] o_beat_data,
    output logic              o_beat_valid,
    input  logic              i_beat_ready,
    output logic              o_beat_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_drained_count
);
    localparam int                LANES       = BEAT_W / RES_W;
    localparam int                LANE_W      = $clog2(LANES) + 1;
    localparam logic [LANE_W-1:0] LANES_CNT   = LANE_W'(LANES);
    localparam logic [CNT_W-1:0]  MAX_RESULTS = CNT_W'(16384);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_WAIT_LAST,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  remaining;
    logic [LANE_W-1:0] lane_cnt;
    logic              inflight;
    logic [BEAT_W-1:0] pack_reg;

    logic [LANE_W-1:0] lane_eff;
    logic [BEAT_W-1:0] pack_eff;
    logic [CNT_W-1:0]  start_count;
    logic              all_read;
    logic              out_free;
    logic              load_beat;
    logic              load_last;
    logic              ren;

    // pack_eff/lane_eff include the word landing this cycle, so a completed
    // beat can move to the output register in the same cycle it is captured.
    always_comb begin
        lane_eff = lane_cnt + LANE_W'(inflight);
        pack_eff = pack_reg;
        for (int k = 0; k < LANES; k++) begin
            if (inflight && (lane_cnt == LANE_W'(k))) begin
                pack_eff[k*RES_W +: RES_W] = i_result_fifo_rdata;
            end
        end

        start_count = (i_num_results > MAX_RESULTS) ? MAX_RESULTS : i_num_results;
        all_read    = (remaining == '0);
        out_free    = !o_beat_valid || i_beat_ready;

        load_beat = 1'b0;
        load_last = 1'b0;
        if (state == S_DRAIN) begin
            if (((lane_eff == LANES_CNT) || (all_read && (lane_eff != '0))) && out_free) begin
                load_beat = 1'b1;
                load_last = all_read;
            end
        end else if ((state == S_FLUSH) && out_free) begin
            load_beat = 1'b1;
            load_last = 1'b1;
        end

        // Counting the in-flight word keeps a held packing register from overflowing.
        ren = (state == S_DRAIN) && !i_result_fifo_empty && !all_read && (lane_eff < LANES_CNT);
    end

    assign o_result_fifo_ren = ren;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= S_IDLE;
            remaining       <= '0;
            lane_cnt        <= '0;
            inflight        <= 1'b0;
            pack_reg        <= '0;
            o_beat_data     <= '0;
            o_beat_valid    <= 1'b0;
            o_beat_last     <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_drained_count <= '0;
        end else begin
            inflight <= ren;
            o_done   <= 1'b0;

            if (ren) begin
                remaining       <= remaining - CNT_W'(1);
                o_drained_count <= o_drained_count + CNT_W'(1);
            end

            if (load_beat) begin
                o_beat_data  <= pack_eff;
                o_beat_valid <= 1'b1;
                o_beat_last  <= load_last;
            end else if (o_beat_valid && i_beat_ready) begin
                o_beat_valid <= 1'b0;
                o_beat_last  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        remaining       <= start_count;
                        o_drained_count <= '0;
                        pack_reg        <= '0;
                        lane_cnt        <= '0;
                        o_busy          <= 1'b1;
                        if (start_count == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (load_beat) begin
                        pack_reg <= '0;
                        lane_cnt <= '0;
                        if (all_read) begin
                            state <= S_WAIT_LAST;
                        end
                    end else begin
                        pack_reg <= pack_eff;
                        lane_cnt <= lane_eff;
                        if (all_read && (lane_eff != '0)) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (load_beat) begin
                        pack_reg <= '0;
                        lane_cnt <= '0;
                        state    <= S_WAIT_LAST;
                    end
                end
                S_WAIT_LAST: begin
                    if (o_beat_valid && i_beat_ready) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_drain_packer.sv
// tb/tb_result_drain_packer.sv - randomized self-checking bench for result_drain_packer
module tb_result_drain_packer;
    localparam int RES_W  = 16;
    localparam int BEAT_W = 256;
    localparam int CNT_W  = 15;
    localparam int LANES  = 16;

    logic              i_clk;
    logic              i_reset_n;
    logic              i_start;
    logic [CNT_W-1:0]  i_num_results;
    logic              o_result_fifo_ren;
    logic [RES_W-1:0]  i_result_fifo_rdata;
    logic              i_result_fifo_empty;
    logic [BEAT_W-1:0] o_beat_data;
    logic              o_beat_valid;
    logic              i_beat_ready;
    logic              o_beat_last;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_drained_count;

    int checks = 0;
    int failures = 0;

    result_drain_packer #(.RES_W(RES_W), .BEAT_W(BEAT_W), .CNT_W(CNT_W)) dut (
        .i_clk               (i_clk),
        .i_reset_n           (i_reset_n),
        .i_start             (i_start),
        .i_num_results       (i_num_results),
        .o_result_fifo_ren   (o_result_fifo_ren),
        .i_result_fifo_rdata (i_result_fifo_rdata),
        .i_result_fifo_empty (i_result_fifo_empty),
        .o_beat_data         (o_beat_data),
        .o_beat_valid        (o_beat_valid),
        .i_beat_ready        (i_beat_ready),
        .o_beat_last         (o_beat_last),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_drained_count     (o_drained_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Result FIFO model: data appears one cycle after the pop strobe.
    logic [RES_W-1:0] fifo_mem [0:32767];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic hold_empty;

    assign i_result_fifo_empty = hold_empty || (rd_ptr >= wr_ptr);

    always @(posedge i_clk) begin
        if (o_result_fifo_ren) begin
            i_result_fifo_rdata <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor: records accepted beats and protocol events at the falling edge.
    int cyc_n = 0, beat_n = 0, ren_n = 0, ren_empty_n = 0, done_n = 0, unstable_n = 0;
    int last_acc = 0, done_gap = 0;
    logic [BEAT_W-1:0] beat_mem [0:2047];
    logic              beat_last_mem [0:2047];
    logic              prev_hold = 1'b0;
    logic [BEAT_W-1:0] prev_data;
    logic              prev_last;

    always @(negedge i_clk) begin
        cyc_n <= cyc_n + 1;
        if (!i_reset_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && (!o_beat_valid || (o_beat_data !== prev_data) || (o_beat_last !== prev_last)))
                unstable_n <= unstable_n + 1;
            prev_hold <= o_beat_valid && !i_beat_ready;
            prev_data <= o_beat_data;
            prev_last <= o_beat_last;
            if (o_beat_valid && i_beat_ready) begin
                if (beat_n < 2048) begin
                    beat_mem[beat_n]      <= o_beat_data;
                    beat_last_mem[beat_n] <= o_beat_last;
                end
                beat_n   <= beat_n + 1;
                last_acc <= cyc_n;
            end
            if (o_result_fifo_ren) begin
                ren_n <= ren_n + 1;
                if (i_result_fifo_empty) ren_empty_n <= ren_empty_n + 1;
            end
            if (o_done) begin
                done_n   <= done_n + 1;
                done_gap <= cyc_n - last_acc;
            end
        end
    end

    // Reference: beat b holds results 16b..16b+15 of the drain in lane order, zero-padded.
    function automatic logic [BEAT_W-1:0] exp_beat(input int base, input int n, input int b);
        logic [BEAT_W-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++)
            if (b * LANES + k < n) v[k*RES_W +: RES_W] = fifo_mem[base + b * LANES + k];
        return v;
    endfunction

    task automatic push(input logic [RES_W-1:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic start_drain(input int n);
        i_num_results = CNT_W'(n);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready, input bit rand_empty, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            i_beat_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            hold_empty   = rand_empty ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
            @(posedge i_clk); #1;
        end
        i_beat_ready = 1'b1;
        hold_empty   = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_start = 1'b0; i_num_results = '0; i_beat_ready = 1'b1; hold_empty = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_beat_valid, o_beat_last, o_busy, o_done, o_result_fifo_ren} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {o_beat_valid, o_beat_last, o_busy, o_done, o_result_fifo_ren});
        end
        checks++;
        if (o_beat_data !== '0 || o_drained_count !== '0) begin
            failures++;
            $display("FAIL reset_data: got data=%h count=%0d expected 0", o_beat_data, o_drained_count);
        end
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_beat_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0 0", o_busy, o_beat_valid);
        end
    endtask

    task automatic test_single_beat();
        int base, b0, d0; bit seen;
        for (int k = 0; k < 16; k++) push(RES_W'(k + 1));
        base = rd_ptr; b0 = beat_n; d0 = done_n;
        start_drain(16);
        wait_done(1'b0, 1'b0, 200, seen);
        checks++;
        if (!seen || beat_n - b0 != 1) begin
            failures++;
            $display("FAIL single_done: got done=%0b beats=%0d expected 1 1", seen, beat_n - b0);
        end
        for (int k = 0; k < 16 && b0 < 2048; k++) begin
            checks++;
            if (beat_mem[b0][k*RES_W +: RES_W] !== RES_W'(k + 1)) begin
                failures++;
                $display("FAIL single_lane%0d: got %h expected %h", k, beat_mem[b0][k*RES_W +: RES_W], k + 1);
            end
        end
        checks++;
        if (beat_last_mem[b0] !== 1'b1 || o_drained_count !== CNT_W'(16) || exp_beat(base, 16, 0) !== beat_mem[b0]) begin
            failures++;
            $display("FAIL single_last_count: got last=%b count=%0d expected 1 16", beat_last_mem[b0], o_drained_count);
        end
        checks++;
        if (done_gap != 1 || done_n - d0 != 1) begin
            failures++;
            $display("FAIL single_done_timing: got gap=%0d pulses=%0d expected 1 1", done_gap, done_n - d0);
        end
    endtask

    task automatic test_partial_last();
        int base, b0, r0, e0, nb; bit seen;
        for (int k = 0; k < 40; k++) push(RES_W'(k + 1));
        base = rd_ptr; b0 = beat_n; r0 = ren_n; e0 = ren_empty_n; nb = 3;
        start_drain(40);
        wait_done(1'b0, 1'b0, 300, seen);
        checks++;
        if (!seen || beat_n - b0 != nb || ren_n - r0 != 40) begin
            failures++;
            $display("FAIL partial_counts: got done=%0b beats=%0d rens=%0d expected 1 3 40", seen, beat_n - b0, ren_n - r0);
        end
        for (int b = 0; b < nb && b0 + b < beat_n; b++) begin
            checks++;
            if (beat_mem[b0+b] !== exp_beat(base, 40, b) || beat_last_mem[b0+b] !== (b == nb - 1)) begin
                failures++;
                $display("FAIL partial_beat%0d: got last=%b data=%h expected last=%b data=%h", b, beat_last_mem[b0+b], beat_mem[b0+b], b == nb - 1, exp_beat(base, 40, b));
            end
        end
        checks++;
        if (o_drained_count !== CNT_W'(40) || ren_empty_n != e0) begin
            failures++;
            $display("FAIL partial_drained: got count=%0d empty_rens=%0d expected 40 0", o_drained_count, ren_empty_n - e0);
        end
    endtask

    task automatic test_backpressure();
        int base, b0, r0, u0, nb; bit seen;
        for (int k = 0; k < 48; k++) push(RES_W'($urandom));
        base = rd_ptr; b0 = beat_n; r0 = ren_n; u0 = unstable_n; nb = 3;
        i_beat_ready = 1'b0;
        start_drain(48);
        repeat (40) @(posedge i_clk);
        #1;
        checks++;
        if (ren_n - r0 != 32) begin
            failures++;
            $display("FAIL stall_ren_count: got %0d expected 32", ren_n - r0);
        end
        checks++;
        if (o_beat_valid !== 1'b1 || o_beat_data !== exp_beat(base, 48, 0)) begin
            failures++;
            $display("FAIL stall_hold: got valid=%b data=%h expected 1 %h", o_beat_valid, o_beat_data, exp_beat(base, 48, 0));
        end
        wait_done(1'b0, 1'b0, 300, seen);
        checks++;
        if (!seen || beat_n - b0 != nb || unstable_n != u0 || o_drained_count !== CNT_W'(48)) begin
            failures++;
            $display("FAIL stall_result: got done=%0b beats=%0d unstable=%0d count=%0d expected 1 3 0 48", seen, beat_n - b0, unstable_n - u0, o_drained_count);
        end
        for (int b = 0; b < nb && b0 + b < beat_n; b++) begin
            checks++;
            if (beat_mem[b0+b] !== exp_beat(base, 48, b) || beat_last_mem[b0+b] !== (b == nb - 1)) begin
                failures++;
                $display("FAIL stall_beat%0d: got last=%b data=%h expected last=%b data=%h", b, beat_last_mem[b0+b], beat_mem[b0+b], b == nb - 1, exp_beat(base, 48, b));
            end
        end
    endtask

    task automatic test_empty_gap();
        int base, b0, r0, e0; bit seen; bit reached;
        base = rd_ptr; b0 = beat_n; r0 = ren_n; e0 = ren_empty_n;
        for (int k = 0; k < 7; k++) push(RES_W'(16'h0a00 + k));
        start_drain(16);
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            if (rd_ptr == base + 7) reached = 1'b1;
            else begin @(posedge i_clk); #1; end
        end
        repeat (5) @(posedge i_clk);
        #1;
        checks++;
        if (!reached || ren_n - r0 != 7) begin
            failures++;
            $display("FAIL gap_pause: got reached=%0b rens=%0d expected 1 7", reached, ren_n - r0);
        end
        for (int k = 7; k < 16; k++) push(RES_W'(16'h0a00 + k));
        wait_done(1'b0, 1'b0, 200, seen);
        checks++;
        if (!seen || ren_empty_n != e0 || ren_n - r0 != 16 || beat_n - b0 != 1) begin
            failures++;
            $display("FAIL gap_result: got done=%0b empty_rens=%0d rens=%0d beats=%0d expected 1 0 16 1", seen, ren_empty_n - e0, ren_n - r0, beat_n - b0);
        end
        checks++;
        if (beat_mem[b0] !== exp_beat(base, 16, 0) || beat_last_mem[b0] !== 1'b1) begin
            failures++;
            $display("FAIL gap_beat: got last=%b data=%h expected last=1 data=%h", beat_last_mem[b0], beat_mem[b0], exp_beat(base, 16, 0));
        end
    endtask

    task automatic test_zero_and_busy();
        int base, b0, r0, d0; bit seen;
        b0 = beat_n; r0 = ren_n; d0 = done_n;
        start_drain(0);
        wait_done(1'b0, 1'b0, 10, seen);
        checks++;
        if (!seen || beat_n != b0 || ren_n != r0 || done_n - d0 != 1 || o_drained_count !== '0) begin
            failures++;
            $display("FAIL zero_drain: got done=%0b beats=%0d rens=%0d pulses=%0d count=%0d expected 1 0 0 1 0", seen, beat_n - b0, ren_n - r0, done_n - d0, o_drained_count);
        end
        for (int k = 0; k < 40; k++) push(RES_W'($urandom));
        base = rd_ptr; b0 = beat_n; r0 = ren_n; d0 = done_n;
        start_drain(32);
        repeat (5) @(posedge i_clk);
        #1;
        i_num_results = CNT_W'(3);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(1'b0, 1'b0, 300, seen);
        checks++;
        if (!seen || o_drained_count !== CNT_W'(32) || ren_n - r0 != 32 || beat_n - b0 != 2 || done_n - d0 != 1) begin
            failures++;
            $display("FAIL busy_restart: got done=%0b count=%0d rens=%0d beats=%0d pulses=%0d expected 1 32 32 2 1", seen, o_drained_count, ren_n - r0, beat_n - b0, done_n - d0);
        end
        for (int b = 0; b < 2 && b0 + b < beat_n; b++) begin
            checks++;
            if (beat_mem[b0+b] !== exp_beat(base, 32, b) || beat_last_mem[b0+b] !== (b == 1)) begin
                failures++;
                $display("FAIL busy_beat%0d: got last=%b data=%h expected last=%b data=%h", b, beat_last_mem[b0+b], beat_mem[b0+b], b == 1, exp_beat(base, 32, b));
            end
        end
        // leftover 8 words from the extra push are consumed so later drains start clean
        base = rd_ptr;
        start_drain(8);
        wait_done(1'b0, 1'b0, 100, seen);
        checks++;
        if (!seen || rd_ptr != base + 8) begin
            failures++;
            $display("FAIL leftover_drain: got done=%0b pops=%0d expected 1 8", seen, rd_ptr - base);
        end
    endtask

    task automatic test_reset_mid_drain();
        int base, b0, d0, cnt; bit seen;
        for (int k = 0; k < 16; k++) push(RES_W'($urandom));
        base = rd_ptr; d0 = done_n;
        start_drain(16);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 10; c++) begin
            @(negedge i_clk);
            if (o_result_fifo_ren) cnt++;
        end
        @(posedge i_clk); #1;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_beat_valid, o_beat_last, o_busy, o_done, o_result_fifo_ren} !== 5'b0 || o_drained_count !== '0 || o_beat_data !== '0) begin
            failures++;
            $display("FAIL async_reset: got flags=%b count=%0d expected 00000 0", {o_beat_valid, o_beat_last, o_busy, o_done, o_result_fifo_ren}, o_drained_count);
        end
        checks++;
        if (rd_ptr - base != 10) begin
            failures++;
            $display("FAIL reset_pops: got %0d expected 10", rd_ptr - base);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (done_n != d0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: got pulses=%0d busy=%b expected 0 0", done_n - d0, o_busy);
        end
        for (int k = 0; k < 10; k++) push(RES_W'($urandom));
        base = rd_ptr; b0 = beat_n;
        start_drain(16);
        wait_done(1'b0, 1'b0, 200, seen);
        checks++;
        if (!seen || beat_n - b0 != 1 || o_drained_count !== CNT_W'(16) || beat_mem[b0] !== exp_beat(base, 16, 0) || beat_last_mem[b0] !== 1'b1) begin
            failures++;
            $display("FAIL after_reset: got done=%0b beats=%0d count=%0d data=%h expected 1 1 16 %h", seen, beat_n - b0, o_drained_count, beat_mem[b0], exp_beat(base, 16, 0));
        end
    endtask

    task automatic test_random();
        int base, b0, r0, e0, u0, n, nb; bit seen;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 90);
            nb = (n + LANES - 1) / LANES;
            for (int k = 0; k < n; k++) push(RES_W'($urandom));
            base = rd_ptr; b0 = beat_n; r0 = ren_n; e0 = ren_empty_n; u0 = unstable_n;
            start_drain(n);
            wait_done(1'b1, 1'b1, 2000, seen);
            checks++;
            if (!seen || beat_n - b0 != nb || ren_n - r0 != n || o_drained_count !== CNT_W'(n) || ren_empty_n != e0 || unstable_n != u0) begin
                failures++;
                $display("FAIL rand%0d_counts: got done=%0b beats=%0d rens=%0d count=%0d empty_rens=%0d unstable=%0d expected 1 %0d %0d %0d 0 0",
                         it, seen, beat_n - b0, ren_n - r0, o_drained_count, ren_empty_n - e0, unstable_n - u0, nb, n, n);
            end
            for (int b = 0; b < nb && b0 + b < beat_n; b++) begin
                checks++;
                if (beat_mem[b0+b] !== exp_beat(base, n, b) || beat_last_mem[b0+b] !== (b == nb - 1)) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d: got last=%b data=%h expected last=%b data=%h", it, b, beat_last_mem[b0+b], beat_mem[b0+b], b == nb - 1, exp_beat(base, n, b));
                end
            end
        end
    endtask

    task automatic test_clamp();
        int base, b0, r0; bit seen;
        for (int k = 0; k < 16384; k++) push(RES_W'($urandom));
        base = rd_ptr; b0 = beat_n; r0 = ren_n;
        start_drain(20000);
        wait_done(1'b0, 1'b0, 20000, seen);
        checks++;
        if (!seen || o_drained_count !== CNT_W'(16384) || ren_n - r0 != 16384 || beat_n - b0 != 1024) begin
            failures++;
            $display("FAIL clamp_counts: got done=%0b count=%0d rens=%0d beats=%0d expected 1 16384 16384 1024", seen, o_drained_count, ren_n - r0, beat_n - b0);
        end
        for (int b = 0; b < 1024 && b0 + b < beat_n && b0 + b < 2048; b++) begin
            checks++;
            if (beat_mem[b0+b] !== exp_beat(base, 16384, b) || beat_last_mem[b0+b] !== (b == 1023)) begin
                failures++;
                $display("FAIL clamp_beat%0d: got last=%b data=%h expected last=%b data=%h", b, beat_last_mem[b0+b], beat_mem[b0+b], b == 1023, exp_beat(base, 16384, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_partial_last();
        test_backpressure();
        test_empty_gap();
        test_zero_and_busy();
        test_reset_mid_drain();
        test_random();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
